// File: rtl/paillier_pkg.sv
// Shared types and constants for the Paillier accelerator control block.
package paillier_pkg;

    typedef enum logic [1:0] {
        ModeEncrypt   = 2'b00,
        ModeDecrypt   = 2'b01,
        ModeHomAdd    = 2'b10,
        ModeScalarMul = 2'b11
    } mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic [3:0] REG_CTRL_OFF      = 4'h0;
    localparam logic [3:0] REG_STATUS_OFF    = 4'h4;
    localparam logic [3:0] REG_BLOCK_NUM_OFF = 4'h8;
    localparam logic [3:0] REG_VERSION_OFF   = 4'hC;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned STATUS_ERR_BIT  = 2;

    localparam logic [31:0] VERSION     = 32'h5041_0001;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

endpackage

// File: rtl/paillier_axi_lite_if.sv
// AXI-Lite slave handshake: independent AW/W latching, registered B and R channels,
// and a simple single-cycle register read/write port towards the register file.
module paillier_axi_lite_if
    import paillier_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESET,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY,
    output logic                reg_wr_en,
    output logic [ADDR_W-1:0]   reg_wr_addr,
    output logic [DATA_W-1:0]   reg_wr_data,
    output logic [DATA_W/8-1:0] reg_wr_strb,
    input  logic                reg_wr_err,
    output logic                reg_rd_en,
    output logic [ADDR_W-1:0]   reg_rd_addr,
    input  logic [DATA_W-1:0]   reg_rd_data
);

    logic                aw_full_q, w_full_q, bvalid_q, rvalid_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [1:0]          bresp_q;

    // Readies are forced low while reset is held so the bus sees an idle slave.
    assign S_AXI_AWREADY = !S_AXI_ARESET && !aw_full_q && !bvalid_q;
    assign S_AXI_WREADY  = !S_AXI_ARESET && !w_full_q && !bvalid_q;
    assign S_AXI_ARREADY = !S_AXI_ARESET && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign reg_wr_en   = aw_full_q && w_full_q;
    assign reg_wr_addr = awaddr_q;
    assign reg_wr_data = wdata_q;
    assign reg_wr_strb = wstrb_q;
    assign reg_rd_en   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign reg_rd_addr = S_AXI_ARADDR;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_full_q <= 1'b1;
                awaddr_q  <= S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_full_q <= 1'b1;
                wdata_q  <= S_AXI_WDATA;
                wstrb_q  <= S_AXI_WSTRB;
            end
            if (reg_wr_en) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= reg_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (reg_rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= reg_rd_data;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/paillier_axi_lite_ctrl.sv
// Control/status register block for the Paillier engine: CTRL, STATUS, BLOCK_NUM, VERSION,
// plus the IDLE/RUN sequencer that issues eng_start and tracks block completion.
module paillier_axi_lite_ctrl
    import paillier_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned BLOCK_CNT_W        = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            eng_start,
    output logic [1:0]                      eng_mode,
    output logic [BLOCK_CNT_W-1:0]          eng_block_num,
    input  logic                            eng_block_done,
    input  logic                            eng_done
);

    logic                            reg_wr_en, reg_wr_err, reg_rd_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   reg_wr_addr, reg_rd_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   reg_wr_data, reg_rd_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] reg_wr_strb;

    state_e                 state_q;
    mode_e                  mode_q, eng_mode_q, mode_new;
    logic [BLOCK_CNT_W-1:0] blk_num_q, eng_blk_q, cnt_q, blk_new;
    logic                   done_q, err_q, eng_start_q, busy;
    logic                   wr_ctrl, wr_status, wr_blk;
    logic                   start_req, start_err, start_ok, blk_zero_err;

    paillier_axi_lite_if #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_if (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_wr_err    (reg_wr_err),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_data   (reg_rd_data)
    );

    assign busy          = (state_q == StRun);
    assign eng_start     = eng_start_q;
    assign eng_mode      = eng_mode_q;
    assign eng_block_num = eng_blk_q;

    always_comb begin
        wr_ctrl   = reg_wr_en && (reg_wr_addr[3:2] == REG_CTRL_OFF[3:2]);
        wr_status = reg_wr_en && (reg_wr_addr[3:2] == REG_STATUS_OFF[3:2]);
        wr_blk    = reg_wr_en && (reg_wr_addr[3:2] == REG_BLOCK_NUM_OFF[3:2]);
        start_req = wr_ctrl && reg_wr_strb[0] && reg_wr_data[CTRL_START_BIT];
        start_err = start_req && busy;
        start_ok  = start_req && !busy && (blk_num_q != '0);
        mode_new  = reg_wr_strb[0] ? mode_e'(reg_wr_data[2:1]) : mode_q;
        blk_new   = blk_num_q;
        for (int i = 0; i < BLOCK_CNT_W; i++) begin
            if (reg_wr_strb[i/8]) blk_new[i] = reg_wr_data[i];
        end
        blk_zero_err = wr_blk && (blk_new == '0);
        reg_wr_err   = start_err || blk_zero_err;
    end

    always_comb begin
        reg_rd_data = '0;
        case (reg_rd_addr[3:2])
            REG_CTRL_OFF[3:2]: reg_rd_data[2:1] = mode_q;
            REG_STATUS_OFF[3:2]: begin
                reg_rd_data[STATUS_BUSY_BIT] = busy;
                reg_rd_data[STATUS_DONE_BIT] = done_q;
                reg_rd_data[STATUS_ERR_BIT]  = err_q;
                reg_rd_data[31:16]           = 16'(cnt_q);
            end
            REG_BLOCK_NUM_OFF[3:2]: reg_rd_data[BLOCK_CNT_W-1:0] = blk_num_q;
            default: reg_rd_data = VERSION;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q     <= StIdle;
            mode_q      <= ModeEncrypt;
            blk_num_q   <= BLOCK_CNT_W'(1);
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            eng_start_q <= 1'b0;
            eng_mode_q  <= ModeEncrypt;
            eng_blk_q   <= BLOCK_CNT_W'(1);
        end else begin
            eng_start_q <= 1'b0;
            if (wr_ctrl && !start_err) mode_q <= mode_new;
            if (wr_blk && !blk_zero_err) blk_num_q <= blk_new;
            if (wr_status && reg_wr_strb[0]) begin
                if (reg_wr_data[STATUS_DONE_BIT]) done_q <= 1'b0;
                if (reg_wr_data[STATUS_ERR_BIT]) err_q <= 1'b0;
            end
            if (start_err) err_q <= 1'b1;
            // Engine events below come after the W1C so a same-cycle eng_done wins.
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q     <= StRun;
                        eng_start_q <= 1'b1;
                        eng_mode_q  <= mode_new;
                        eng_blk_q   <= blk_num_q;
                        cnt_q       <= '0;
                        done_q      <= 1'b0;
                    end
                end
                StRun: begin
                    if (eng_block_done && (cnt_q != '1)) cnt_q <= cnt_q + BLOCK_CNT_W'(1);
                    if (eng_done) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, reg_wr_addr, reg_rd_addr, reg_wr_data,
                         reg_wr_strb, reg_rd_en};

endmodule

// File: tb/tb_paillier_axi_lite_ctrl.sv
// Self-checking bench for paillier_axi_lite_ctrl: vector table of register accesses plus
// hand-written engine and handshake sequences; read data is checked through a scoreboard queue.
module tb_paillier_axi_lite_ctrl;

    logic        clk, rst;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp, eng_mode;
    logic        eng_start, eng_block_done, eng_done;
    logic [15:0] eng_block_num;

    int passed = 0;
    int total = 0;
    int start_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    paillier_axi_lite_ctrl dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESET   (rst),
        .S_AXI_AWADDR   (awaddr),
        .S_AXI_AWPROT   (awprot),
        .S_AXI_AWVALID  (awvalid),
        .S_AXI_AWREADY  (awready),
        .S_AXI_WDATA    (wdata),
        .S_AXI_WSTRB    (wstrb),
        .S_AXI_WVALID   (wvalid),
        .S_AXI_WREADY   (wready),
        .S_AXI_BRESP    (bresp),
        .S_AXI_BVALID   (bvalid),
        .S_AXI_BREADY   (bready),
        .S_AXI_ARADDR   (araddr),
        .S_AXI_ARPROT   (arprot),
        .S_AXI_ARVALID  (arvalid),
        .S_AXI_ARREADY  (arready),
        .S_AXI_RDATA    (rdata),
        .S_AXI_RRESP    (rresp),
        .S_AXI_RVALID   (rvalid),
        .S_AXI_RREADY   (rready),
        .eng_start      (eng_start),
        .eng_mode       (eng_mode),
        .eng_block_num  (eng_block_num),
        .eng_block_done (eng_block_done),
        .eng_done       (eng_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (eng_start === 1'b1) start_cnt++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input bit wr, input logic [3:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.exp = e;
        return v;
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        bit aw_f, w_f, aw_done, w_done;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(negedge clk);
            if (aw_f) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_f) begin wvalid = 1'b0; w_done = 1'b1; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) begin
            check("bvalid_timeout", 32'(bvalid), 32'd1);
            resp = 2'b11;
            return;
        end
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
        int n;
        logic [31:0] e;
        exp_q.push_back(exp);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) begin
            check({nm, "_arready_timeout"}, 32'(arready), 32'd1);
            arvalid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        check({nm, "_rvalid_early"}, 32'(rvalid), 32'd0);
        @(negedge clk);
        arvalid = 1'b0;
        check({nm, "_rvalid_lat"}, 32'(rvalid), 32'd1);
        e = exp_q.pop_front();
        check(nm, rdata, e);
        check({nm, "_rresp"}, 32'(rresp), 32'd0);
        @(negedge clk);
    endtask

    task automatic eng_pulse(input logic bd, input logic d);
        eng_block_done = bd; eng_done = d;
        @(negedge clk);
        eng_block_done = 1'b0; eng_done = 1'b0;
    endtask

    initial begin
        logic [1:0] resp;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        eng_block_done = 0; eng_done = 0;
        rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_eng_mode", 32'(eng_mode), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", 32'(awready), 32'd1);

        // Register-map vectors: writes compare BRESP, reads compare RDATA.
        vecs.push_back(mk(0, 4'hC, 32'h0, 4'h0, 32'h5041_0001));
        vecs.push_back(mk(0, 4'h0, 32'h0, 4'h0, 32'h0000_0000));
        vecs.push_back(mk(0, 4'h4, 32'h0, 4'h0, 32'h0000_0000));
        vecs.push_back(mk(0, 4'h8, 32'h0, 4'h0, 32'h0000_0001));
        vecs.push_back(mk(1, 4'hC, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vecs.push_back(mk(0, 4'hC, 32'h0, 4'h0, 32'h5041_0001));
        vecs.push_back(mk(1, 4'h8, 32'h0, 4'hF, 32'h2));
        vecs.push_back(mk(0, 4'h8, 32'h0, 4'h0, 32'h0000_0001));
        vecs.push_back(mk(1, 4'h8, 32'h1234_0007, 4'h1, 32'h0));
        vecs.push_back(mk(0, 4'h8, 32'h0, 4'h0, 32'h0000_0007));
        vecs.push_back(mk(1, 4'h8, 32'h0000_0300, 4'h2, 32'h0));
        vecs.push_back(mk(0, 4'h8, 32'h0, 4'h0, 32'h0000_0307));
        vecs.push_back(mk(1, 4'h8, 32'hAB00_0000, 4'h8, 32'h0));
        vecs.push_back(mk(0, 4'h8, 32'h0, 4'h0, 32'h0000_0307));
        vecs.push_back(mk(1, 4'h0, 32'h0000_0006, 4'h0, 32'h0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 4'h0, 32'h0000_0000));
        vecs.push_back(mk(1, 4'h0, 32'h0000_0006, 4'h1, 32'h0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 4'h0, 32'h0000_0006));
        vecs.push_back(mk(1, 4'h8, 32'h0000_0003, 4'hF, 32'h0));
        vecs.push_back(mk(1, 4'h4, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vecs.push_back(mk(0, 4'h4, 32'h0, 4'h0, 32'h0000_0000));
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d_bresp", i), 32'(resp), vecs[i].exp);
            end else begin
                axi_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rdata", i));
            end
        end

        // Start: mode 10, three blocks.
        axi_write(4'h0, 32'h0000_0005, 4'hF, resp);
        check("start_bresp", 32'(resp), 32'd0);
        check("start_pulses", 32'(start_cnt), 32'd1);
        check("start_mode", 32'(eng_mode), 32'd2);
        check("start_blocks", 32'(eng_block_num), 32'd3);
        axi_read(4'h4, 32'h0000_0001, "status_busy");
        axi_read(4'h0, 32'h0000_0004, "ctrl_mode10");

        // START while busy is rejected.
        axi_write(4'h0, 32'h0000_0007, 4'hF, resp);
        check("busy_start_bresp", 32'(resp), 32'd2);
        check("busy_start_pulses", 32'(start_cnt), 32'd1);
        check("busy_start_mode", 32'(eng_mode), 32'd2);
        axi_read(4'h0, 32'h0000_0004, "busy_ctrl_unchanged");
        axi_read(4'h4, 32'h0000_0005, "status_err");

        // Shadow writes in RUN leave engine outputs frozen.
        axi_write(4'h8, 32'h0000_0009, 4'hF, resp);
        check("run_blk_bresp", 32'(resp), 32'd0);
        check("run_blk_frozen", 32'(eng_block_num), 32'd3);
        axi_write(4'h0, 32'h0000_0002, 4'hF, resp);
        check("run_mode_frozen", 32'(eng_mode), 32'd2);
        axi_read(4'h0, 32'h0000_0002, "run_ctrl_shadow");
        axi_write(4'h4, 32'h0000_0004, 4'hF, resp);
        axi_read(4'h4, 32'h0000_0001, "err_cleared");

        // Two blocks, then third block coincident with eng_done.
        eng_pulse(1'b1, 1'b0);
        eng_pulse(1'b1, 1'b0);
        eng_pulse(1'b1, 1'b1);
        axi_read(4'h4, 32'h0003_0002, "status_done3");
        eng_pulse(1'b1, 1'b1);
        axi_read(4'h4, 32'h0003_0002, "idle_events_ignored");
        axi_write(4'h4, 32'h0000_0002, 4'hF, resp);
        axi_read(4'h4, 32'h0003_0000, "done_w1c");

        // Second run: W1C of DONE commits on the same edge as eng_done.
        axi_write(4'h0, 32'h0000_0001, 4'hF, resp);
        check("run2_pulses", 32'(start_cnt), 32'd2);
        check("run2_mode", 32'(eng_mode), 32'd0);
        check("run2_blocks", 32'(eng_block_num), 32'd9);
        awaddr = 4'h4; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        check("w1c_race_ready", 32'(awready && wready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        check("w1c_race_bvalid", 32'(bvalid), 32'd1);
        @(negedge clk);
        axi_read(4'h4, 32'h0000_0002, "done_set_wins");
        axi_write(4'h4, 32'h0000_0002, 4'hF, resp);

        // W three cycles ahead of AW, BREADY low for four cycles.
        bready = 1'b0;
        awaddr = 4'h8; wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        check("early_w_ready", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        awvalid = 1'b1;
        check("late_aw_ready", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        check("commit_not_yet", 32'(bvalid), 32'd0);
        @(negedge clk);
        check("commit_bvalid", 32'(bvalid), 32'd1);
        wdata = 32'h6; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bhold%0d_bvalid", i), 32'(bvalid), 32'd1);
            check($sformatf("bhold%0d_bresp", i), 32'(bresp), 32'd0);
            check($sformatf("bhold%0d_blocked", i), 32'(awready || wready), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        check("bhold_released", 32'(bvalid), 32'd0);
        axi_read(4'h8, 32'h0000_0005, "single_commit");

        // Reset in RUN with a read response pending.
        axi_write(4'h0, 32'h0000_0003, 4'hF, resp);
        check("run3_pulses", 32'(start_cnt), 32'd3);
        check("run3_mode", 32'(eng_mode), 32'd1);
        check("run3_blocks", 32'(eng_block_num), 32'd5);
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        check("pending_rvalid", 32'(rvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_rvalid", 32'(rvalid), 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_arready", 32'(arready), 32'd0);
        check("arst_eng_mode", 32'(eng_mode), 32'd0);
        check("arst_eng_start", 32'(eng_start), 32'd0);
        @(negedge clk);
        rst = 1'b0; rready = 1'b1;
        @(negedge clk);
        check("arst_discarded", 32'(rvalid), 32'd0);
        axi_read(4'h4, 32'h0000_0000, "arst_status_idle");
        axi_read(4'h8, 32'h0000_0001, "arst_block_num");
        axi_read(4'h0, 32'h0000_0000, "arst_ctrl");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/paillier_axi_lite_ctrl.md
Name: paillier_axi_lite_ctrl

Overview:
AXI-Lite slave control/status register block for the Paillier accelerator. It terminates the host-side AXI-Lite bus and holds the operation mode and block count. It issues a single-cycle start to the Paillier engine and AXI-Full master, then tracks completion through busy/done status. It sits between the host (or bench AXI-Lite stimulus master) and the engine core inside the Paillier AXI top.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; four 32-bit registers at 0x0/0x4/0x8/0xC.
BLOCK_CNT_W, 16, width of block-count fields.

Ports:
S_AXI_ACLK  in  1  sole clock.
S_AXI_ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel; AWPROT ignored.
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_W/3/1/1  read address; ARPROT ignored.
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data.
eng_start  out  1  one-cycle start pulse.
eng_mode  out  2  00 encrypt, 01 decrypt, 10 homomorphic add, 11 scalar mul.
eng_block_num  out  BLOCK_CNT_W  blocks to process.
eng_block_done  in  1  pulse per finished block.
eng_done  in  1  pulse when the whole operation finishes.

Behaviour:
- Register map:
  - 0x0 CTRL: [0] START (write-1, reads 0); [2:1] MODE.
  - 0x4 STATUS: [0] BUSY (RO); [1] DONE (sticky, write-1-to-clear); [2] ERR (sticky, W1C); [31:16] blocks completed (RO).
  - 0x8 BLOCK_NUM: [BLOCK_CNT_W-1:0] RW; upper bits read 0.
  - 0xC VERSION: RO constant 32'h5041_0001.
- Reset: all ready/valid outputs 0; BRESP and RRESP 00; RDATA 0; MODE 00; BLOCK_NUM 1; DONE/ERR/count 0; eng_start 0; FSM in IDLE.
- Write channel:
  - AW and W are accepted independently: AWREADY is high while no address is latched and BVALID is low; WREADY likewise for data.
  - The write commits in the cycle after both address and data are latched; BVALID rises on that same commit edge and holds until BREADY.
  - No new AW/W is accepted while BVALID is high.
  - WSTRB is honoured per byte for CTRL and BLOCK_NUM.
- Read channel:
  - ARREADY is high when RVALID is low.
  - RDATA/RVALID are registered, giving one-cycle latency; RVALID holds until RREADY.
  - Read and write channels operate concurrently.
- Responses:
  - BRESP = 10 (SLVERR) when START=1 is written while BUSY. That write also sets ERR and leaves MODE unchanged.
  - BRESP = 10 when BLOCK_NUM is written with 0; the register keeps its old value.
  - Writes to RO registers are dropped and return OKAY.
  - All reads return OKAY.
- FSM, states IDLE and RUN:
  - IDLE→RUN: a committed START with BLOCK_NUM≠0. This asserts eng_start for exactly one cycle on the following edge, clears the block count and DONE, and sets BUSY.
  - In RUN: MODE and BLOCK_NUM writes are accepted into the shadow register, but eng_mode/eng_block_num stay frozen at the values captured at start.
  - RUN→IDLE: on eng_done. This sets DONE and clears BUSY the next cycle.
- Block counter: increments on eng_block_done in RUN only and saturates at all-ones.
- Simultaneous events:
  - eng_done together with a W1C of DONE: set wins.
  - eng_block_done on the same cycle as eng_done: counted.
  - eng_done or eng_block_done while in IDLE: ignored.
- Reset mid-operation: asynchronous return to reset values; any pending B/R response is discarded.

Decomposition:
- Shared package paillier_pkg: mode enum (encrypt/decrypt/homomorphic add/scalar mul), register offset constants, STATUS bit positions, VERSION constant, response codes OKAY/SLVERR.
- One sub-module: paillier_axi_lite_if, holding the AXI-Lite handshake and address/data latching. It presents a reg_wr_en/addr/data/strb and reg_rd_en/addr/data interface to the register/FSM logic.

Test Plan:
- Reset then read 0xC → RDATA 32'h5041_0001, RRESP 00, exactly one cycle after the AR handshake.
- Write 0x8=3, then 0x0=32'h0000_0005 (mode 10, start) → single eng_start pulse, eng_mode=10, eng_block_num=3, STATUS=32'h0000_0001.
- Drive 3 eng_block_done then eng_done → STATUS=32'h0003_0002. Write 0x4=2 → STATUS=32'h0003_0000.
- Write START while BUSY → BRESP=10, no eng_start, STATUS[2]=1, eng_mode unchanged.
- Present W three cycles before AW, with BREADY held low for 4 cycles → single commit, BVALID held steady, no second write accepted.
- Assert S_AXI_ARESET mid-RUN with RVALID pending → all outputs return to reset values immediately, FSM in IDLE, BLOCK_NUM=1.
